// File: rtl/framebuffer_writer.sv
// Renderer pixel stream to framebuffer BRAM port A: bounds check, 12-bit colour
// quantisation, linear addressing, frame tracking and double-buffer swap handshake.
module framebuffer_writer #(
  parameter int unsigned START_X       = 390,
  parameter int unsigned START_Y       = 390,
  parameter int unsigned END_X         = 634,
  parameter int unsigned END_Y         = 765,
  parameter int unsigned DOUBLE_BUFFER = 1,
  parameter int unsigned ADDR_WIDTH    = 18
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [23:0]           pixel_axis_tdata,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  pixel_axis_tvalid,
  output logic                  pixel_axis_tready,
  input  logic                  swap_ack_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [11:0]           data_out,
  output logic                  we_out,
  output logic                  write_bank_out,
  output logic                  display_bank_out,
  output logic                  frame_done_out,
  output logic [16:0]           last_frame_count_out,
  output logic [15:0]           oob_count_out
);

  localparam int unsigned WIDTH        = END_X - START_X;
  localparam int unsigned FRAME_PIXELS = WIDTH * (END_Y - START_Y);

  localparam logic [1:0] ST_WRITE     = 2'd0;
  localparam logic [1:0] ST_DRAIN     = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        accept;
  logic        in_region;
  logic        is_last;
  logic        s1_valid;
  logic        s1_in_region;
  logic [10:0] s1_x_off;
  logic [9:0]  s1_y_off;
  logic [11:0] s1_color;
  logic        s1_last;
  logic        s1_write;
  logic [16:0] run_count;
  logic [ADDR_WIDTH-1:0] bank_base;

  assign pixel_axis_tready = (state == ST_WRITE) && !rst_in;
  assign accept            = pixel_axis_tvalid && pixel_axis_tready;
  assign display_bank_out  = (DOUBLE_BUFFER != 0) ? (~write_bank_out & ~rst_in) : 1'b0;

  // Region test on raw coordinates, before any offset subtraction can wrap
  assign in_region = (32'(hcount_in) >= START_X) && (32'(hcount_in) < END_X) &&
                     (32'(vcount_in) >= START_Y) && (32'(vcount_in) < END_Y);
  assign is_last   = in_region && (32'(hcount_in) == END_X - 1) &&
                     (32'(vcount_in) == END_Y - 1);

  assign s1_write  = s1_valid && s1_in_region;
  assign bank_base = write_bank_out ? ADDR_WIDTH'(FRAME_PIXELS) : '0;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_WRITE;
    else        state <= state_nxt;
  end

  // Next-state logic; DRAIN holds until the last pixel's write cycle has been issued
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WRITE:     if (accept && is_last) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (frame_done_out) state_nxt = (DOUBLE_BUFFER != 0) ? ST_WAIT_SWAP : ST_WRITE;
      ST_WAIT_SWAP: if (swap_ack_in) state_nxt = ST_WRITE;
      default:      state_nxt = ST_WRITE;
    endcase
  end

  // Stage 1: offsets, quantised colour and flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid     <= 1'b0;
      s1_in_region <= 1'b0;
      s1_x_off     <= '0;
      s1_y_off     <= '0;
      s1_color     <= '0;
      s1_last      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_in_region <= in_region;
        s1_x_off     <= hcount_in - 11'(START_X);
        s1_y_off     <= vcount_in - 10'(START_Y);
        s1_color     <= {pixel_axis_tdata[23:20], pixel_axis_tdata[15:12], pixel_axis_tdata[7:4]};
        s1_last      <= is_last;
      end
    end
  end

  // Stage 2: BRAM write port and frame accounting
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_out             <= '0;
      data_out             <= '0;
      we_out               <= 1'b0;
      frame_done_out       <= 1'b0;
      last_frame_count_out <= '0;
      run_count            <= '0;
    end else begin
      we_out         <= s1_write;
      frame_done_out <= 1'b0;
      if (s1_write) begin
        addr_out <= bank_base + ADDR_WIDTH'(s1_x_off) + ADDR_WIDTH'(32'(s1_y_off) * WIDTH);
        data_out <= s1_color;
        if (s1_last) begin
          frame_done_out       <= 1'b1;
          last_frame_count_out <= run_count + 17'd1;
          run_count            <= '0;
        end else begin
          run_count <= run_count + 17'd1;
        end
      end
    end
  end

  // Dropped-beat counter and bank select
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      oob_count_out  <= '0;
      write_bank_out <= 1'b0;
    end else begin
      if (accept && !in_region && (oob_count_out != 16'hFFFF))
        oob_count_out <= oob_count_out + 16'd1;
      if ((state == ST_WAIT_SWAP) && swap_ack_in)
        write_bank_out <= ~write_bank_out;
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomised scoreboard bench for framebuffer_writer: a coordinate-level model
// predicts every BRAM write; a negedge monitor pops and compares.
module tb_framebuffer_writer;

  localparam int SX = 390, SY = 390, EX = 634, EY = 765;
  localparam int W  = EX - SX;
  localparam int FP = W * (EY - SY);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic        swap_ack = 1'b0;
  logic [23:0] tdata = '0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;

  logic        a_tready, a_we, a_wb, a_db, a_fd;
  logic [17:0] a_addr;
  logic [11:0] a_data;
  logic [16:0] a_lfc;
  logic [15:0] a_oob;
  logic        s_tready, s_we, s_wb, s_db, s_fd;
  logic [17:0] s_addr;
  logic [11:0] s_data;
  logic [16:0] s_lfc;
  logic [15:0] s_oob;

  always #5 clk = ~clk;

  framebuffer_writer dut (
    .clk_in(clk), .rst_in(rst), .pixel_axis_tdata(tdata), .hcount_in(hc), .vcount_in(vc),
    .pixel_axis_tvalid(tvalid), .pixel_axis_tready(a_tready), .swap_ack_in(swap_ack),
    .addr_out(a_addr), .data_out(a_data), .we_out(a_we), .write_bank_out(a_wb),
    .display_bank_out(a_db), .frame_done_out(a_fd), .last_frame_count_out(a_lfc),
    .oob_count_out(a_oob));

  framebuffer_writer #(.DOUBLE_BUFFER(0)) dut_single (
    .clk_in(clk), .rst_in(rst), .pixel_axis_tdata(tdata), .hcount_in(hc), .vcount_in(vc),
    .pixel_axis_tvalid(tvalid), .pixel_axis_tready(s_tready), .swap_ack_in(swap_ack),
    .addr_out(s_addr), .data_out(s_data), .we_out(s_we), .write_bank_out(s_wb),
    .display_bank_out(s_db), .frame_done_out(s_fd), .last_frame_count_out(s_lfc),
    .oob_count_out(s_oob));

  typedef struct {int addr; int data; bit last; int lfc;} exp_t;
  exp_t q[$];
  int   m_bank, m_run, m_oob;
  int   n_vec = 0, n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int quant(int d);
    return ((d >> 20) & 15) * 256 + ((d >> 12) & 15) * 16 + ((d >> 4) & 15);
  endfunction

  // Reference model: what one accepted beat means for the framebuffer
  function automatic void model_beat(int h, int v, int d);
    exp_t e;
    if (h >= SX && h < EX && v >= SY && v < EY) begin
      m_run++;
      e.addr = m_bank * FP + (h - SX) + (v - SY) * W;
      e.data = quant(d);
      e.last = (h == EX - 1) && (v == EY - 1);
      e.lfc  = m_run;
      if (e.last) m_run = 0;
      q.push_back(e);
    end else if (m_oob < 65535) begin
      m_oob++;
    end
  endfunction

  // Monitor: every write the DUT issues must be the next predicted one
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (a_we) begin
        if (q.size() == 0) chk("unexpected_write", 32'(a_we), 32'd0);
        else begin
          e = q.pop_front();
          chk("addr", 32'(a_addr), 32'(e.addr));
          chk("data", 32'(a_data), 32'(e.data));
          chk("frame_done", 32'(a_fd), 32'(e.last));
          if (e.last) chk("last_frame_count", 32'(a_lfc), 32'(e.lfc));
        end
      end else if (a_fd) begin
        chk("frame_done_without_write", 32'(a_fd), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int h, input int v, input int d);
    int k = 0;
    hc = 11'(h); vc = 10'(v); tdata = 24'(d); tvalid = 1'b1;
    @(negedge clk);
    while (!a_tready && k < 200) begin k++; @(negedge clk); end
    if (!a_tready) begin
      chk("tready_timeout", 32'(a_tready), 32'd1);
      tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(h, v, d);
    #1 tvalid = 1'b0;
  endtask

  task automatic wait_empty();
    int k = 0;
    while (q.size() != 0 && k < 20) begin @(posedge clk); k++; end
    #1;
    chk("pending_writes", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; swap_ack = 1'b0;
    q.delete(); m_bank = 0; m_run = 0; m_oob = 0;
    @(negedge clk);
    chk("rst_a_ctrl", {27'd0, a_tready, a_we, a_wb, a_db, a_fd}, 32'd0);
    chk("rst_a_addr_data", {2'd0, a_addr, a_data}, 32'd0);
    chk("rst_a_counts", {a_lfc[15:0], a_oob}, 32'd0);
    chk("rst_a_lfc_msb", 32'(a_lfc[16]), 32'd0);
    chk("rst_s_ctrl", {27'd0, s_tready, s_we, s_wb, s_db, s_fd}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", 32'(a_tready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_beats(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(640, 380);
      v = $urandom_range(770, 380);
      if (h == EX - 1 && v == EY - 1) h = SX;
      send(h, v, int'($urandom));
      if ($urandom_range(3, 0) == 0) idle(1);
    end
  endtask

  // Last beat, then hold off the ack for 50 cycles and check the stall
  task automatic end_frame();
    int hi = 0;
    send(EX - 1, EY - 1, int'($urandom));
    @(negedge clk);
    chk("tready_low_after_last", 32'(a_tready), 32'd0);
    repeat (50) begin @(negedge clk); if (a_tready) hi++; end
    chk("stall_without_ack", 32'(hi), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_swap();
    swap_ack = 1'b1;
    @(posedge clk); #1 swap_ack = 1'b0;
    m_bank ^= 1;
    @(negedge clk);
    chk("write_bank_after_ack", 32'(a_wb), 32'(m_bank));
    chk("display_bank_after_ack", 32'(a_db), 32'(1 - m_bank));
    chk("tready_after_ack", 32'(a_tready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Single known beat, then two dropped beats
    send(390, 390, 'hABCDEF);
    wait_empty();
    send(389, 400, int'($urandom));
    send(500, 765, int'($urandom));
    idle(2);
    chk("oob_two", 32'(a_oob), 32'(m_oob));

    // Sparse random frame in bank 0, then swap and write the first pixel of bank 1
    rand_beats(400);
    end_frame();
    wait_empty();
    do_swap();
    send(390, 390, int'($urandom));
    wait_empty();

    // Ack during WRITE has no effect
    swap_ack = 1'b1; idle(1); swap_ack = 1'b0; idle(1);
    chk("bank_stable_ack_in_write", 32'(a_wb), 32'(m_bank));

    // Frame in bank 1 with duplicates; ack during DRAIN is lost
    rand_beats(300);
    send(EX - 1, EY - 1, int'($urandom));
    swap_ack = 1'b1;
    idle(2);
    swap_ack = 1'b0;
    idle(5);
    chk("tready_after_lost_ack", 32'(a_tready), 32'd0);
    chk("bank_after_lost_ack", 32'(a_wb), 32'(m_bank));
    wait_empty();
    do_swap();
    rand_beats(50);
    wait_empty();

    // Single-bank instance: back to WRITE right after the final write
    do_reset();
    send(EX - 1, EY - 1, 'h123456);
    @(negedge clk);
    chk("single_tready_drain", 32'(s_tready), 32'd0);
    @(negedge clk);
    chk("single_we", 32'(s_we), 32'd1);
    chk("single_frame_done", 32'(s_fd), 32'd1);
    chk("single_addr", 32'(s_addr), 32'(FP - 1));
    chk("single_data", 32'(s_data), 32'(quant('h123456)));
    chk("single_lfc", 32'(s_lfc), 32'd1);
    @(negedge clk);
    chk("single_tready_resume", 32'(s_tready), 32'd1);
    chk("single_banks", {30'd0, s_wb, s_db}, 32'd0);
    @(posedge clk); #1;

    // Reset right after a beat is accepted: it must never be written
    do_reset();
    send(400, 400, int'($urandom));
    do_reset();
    idle(4);
    chk("no_write_after_flush", 32'(a_we), 32'd0);

    // Saturating drop counter
    for (int i = 0; i < 65540; i++) send(100, 100, 0);
    idle(2);
    chk("oob_saturated", 32'(a_oob), 32'(m_oob));
    for (int i = 0; i < 5; i++) send(700, 10, 0);
    idle(2);
    chk("oob_holds", 32'(a_oob), 32'(m_oob));

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
